// File: rtl/fir_tap_accumulator.sv
// Frame accumulator for FIR tap products: sums NUM_TAPS unsigned products per output sample.
// Optional clamping on overflow is enabled by defining FIR_ACC_SATURATE_EN.
module fir_tap_accumulator #(
  parameter int NUM_TAPS = 4,
  parameter int ACC_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_prod,
  output logic [3:0]       tap_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             sat_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [3:0]       count, count_nxt;
  logic             out_valid_nxt;
  logic [ACC_W-1:0] out_sum_nxt;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             accept;

  // HOLD back-pressures upstream until the finished sum is consumed.
  assign in_ready = (state == HOLD) ? out_ready : 1'b1;
  assign accept   = in_valid & in_ready & ~clr;
  assign prod_ext = ACC_W'(in_prod);
  assign tap_idx  = count;

`ifdef FIR_ACC_SATURATE_EN
  logic [ACC_W:0] sum_full;
  logic           sat_q;

  assign sum_full = {1'b0, acc} + {1'b0, prod_ext};
  assign sum      = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_q <= 1'b0;
    end else if (clr) begin
      sat_q <= 1'b0;
    end else if (accept && (state == ACCUM) && sum_full[ACC_W]) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign sum      = acc + prod_ext;
  assign sat_flag = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    count_nxt     = count;
    out_valid_nxt = out_valid;
    out_sum_nxt   = out_sum;

    if (clr) begin
      state_nxt     = IDLE;
      acc_nxt       = '0;
      count_nxt     = '0;
      out_valid_nxt = 1'b0;
      out_sum_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt   = prod_ext;
            count_nxt = 4'd1;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (count == LAST_TAP) begin
              out_sum_nxt   = sum;
              out_valid_nxt = 1'b1;
              count_nxt     = '0;
              state_nxt     = HOLD;
            end else begin
              acc_nxt   = sum;
              count_nxt = count + 4'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_nxt = 1'b0;
            if (accept) begin
              // Zero-bubble: the first product of the next frame lands with the handoff.
              acc_nxt   = prod_ext;
              count_nxt = 4'd1;
              state_nxt = ACCUM;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      out_sum   <= out_sum_nxt;
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench for fir_tap_accumulator: table of per-cycle vectors plus hand sequences
// for saturation/wrap (ACC_W=5 instance) and asynchronous reset mid-frame.
module tb_fir_tap_accumulator;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [3:0] prod;
    logic       ordy;
    logic       rdy;
    logic [3:0] tap;
    logic       ov;
    logic [7:0] sum;
  } vec_t;

`ifdef FIR_ACC_SATURATE_EN
  localparam logic [4:0] EXP_SUM5 = 5'd31;
  localparam logic       EXP_SAT5 = 1'b1;
`else
  localparam logic [4:0] EXP_SUM5 = 5'd4;
  localparam logic       EXP_SAT5 = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_prod;
  logic [3:0] tap_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       sat_flag;

  logic       in_ready5;
  logic [3:0] tap_idx5;
  logic       out_valid5;
  logic [4:0] out_sum5;
  logic       sat_flag5;

  int n_checks = 0;
  int n_fail   = 0;

  fir_tap_accumulator #(.NUM_TAPS(4), .ACC_W(8)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .tap_idx(tap_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .sat_flag(sat_flag)
  );

  fir_tap_accumulator #(.NUM_TAPS(4), .ACC_W(5)) dut5 (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready5), .in_prod(in_prod),
    .tap_idx(tap_idx5), .out_valid(out_valid5), .out_ready(out_ready),
    .out_sum(out_sum5), .sat_flag(sat_flag5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic v, input logic [3:0] p, input logic o,
                              input logic r, input logic [3:0] t, input logic ov, input logic [7:0] s);
    vec_t x;
    x.clr = c; x.vld = v; x.prod = p; x.ordy = o;
    x.rdy = r; x.tap = t; x.ov = ov; x.sum = s;
    return x;
  endfunction

  // One clock: drive at negedge, check in_ready before the edge, registered outputs after it.
  task automatic drive(input vec_t v, input string tag);
    @(negedge clk);
    clr       = v.clr;
    in_valid  = v.vld;
    in_prod   = v.prod;
    out_ready = v.ordy;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    check({tag, " tap_idx"}, 32'(tap_idx), 32'(v.tap));
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.ov));
    check({tag, " out_sum"}, 32'(out_sum), 32'(v.sum));
    check({tag, " sat_flag"}, 32'(sat_flag), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];

    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = 4'd0; out_ready = 1'b1;
    #2;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst tap_idx", 32'(tap_idx), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_sum", 32'(out_sum), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Four 9s, one-cycle latency, handoff to IDLE.
    tbl.push_back(mk(0,1,9,1, 1,1,0,0));
    tbl.push_back(mk(0,1,9,1, 1,2,0,0));
    tbl.push_back(mk(0,1,9,1, 1,3,0,0));
    tbl.push_back(mk(0,1,9,1, 1,0,1,36));
    tbl.push_back(mk(0,0,0,1, 1,0,0,36));
    // 1,2,3,4 then downstream stalls three cycles; in_valid must be ignored.
    tbl.push_back(mk(0,1,1,0, 1,1,0,36));
    tbl.push_back(mk(0,1,2,0, 1,2,0,36));
    tbl.push_back(mk(0,1,3,0, 1,3,0,36));
    tbl.push_back(mk(0,1,4,0, 1,0,1,10));
    tbl.push_back(mk(0,1,7,0, 0,0,1,10));
    tbl.push_back(mk(0,1,7,0, 0,0,1,10));
    tbl.push_back(mk(0,1,7,0, 0,0,1,10));
    // Continuous 1..8: first product accepted on the HOLD handoff, sums 10 and 26.
    tbl.push_back(mk(0,1,1,1, 1,1,0,10));
    tbl.push_back(mk(0,1,2,1, 1,2,0,10));
    tbl.push_back(mk(0,1,3,1, 1,3,0,10));
    tbl.push_back(mk(0,1,4,1, 1,0,1,10));
    tbl.push_back(mk(0,1,5,1, 1,1,0,10));
    tbl.push_back(mk(0,1,6,1, 1,2,0,10));
    tbl.push_back(mk(0,1,7,1, 1,3,0,10));
    tbl.push_back(mk(0,1,8,1, 1,0,1,26));
    tbl.push_back(mk(0,0,0,1, 1,0,0,26));
    // Abort after 5,5 then 1,1,1,1.
    tbl.push_back(mk(0,1,5,1, 1,1,0,26));
    tbl.push_back(mk(0,1,5,1, 1,2,0,26));
    tbl.push_back(mk(1,1,5,1, 1,0,0,0));
    tbl.push_back(mk(0,1,1,1, 1,1,0,0));
    tbl.push_back(mk(0,1,1,1, 1,2,0,0));
    tbl.push_back(mk(0,1,1,1, 1,3,0,0));
    tbl.push_back(mk(0,1,1,1, 1,0,1,4));
    // clr in HOLD while downstream stalls.
    tbl.push_back(mk(1,1,1,0, 0,0,0,0));
    // Stall inside ACCUM keeps count.
    tbl.push_back(mk(0,1,3,1, 1,1,0,0));
    tbl.push_back(mk(0,0,3,1, 1,1,0,0));
    tbl.push_back(mk(0,1,3,1, 1,2,0,0));
    tbl.push_back(mk(1,0,0,1, 1,0,0,0));

    foreach (tbl[i]) drive(tbl[i], $sformatf("v%0d", i));

    // Overflow on the ACC_W=5 instance: 9+9+9+9 = 36 > 31.
    drive(mk(0,1,9,1, 1,1,0,0), "sat1");
    drive(mk(0,1,9,1, 1,2,0,0), "sat2");
    drive(mk(0,1,9,1, 1,3,0,0), "sat3");
    drive(mk(0,1,9,1, 1,0,1,36), "sat4");
    check("sat out_valid5", 32'(out_valid5), 32'd1);
    check("sat out_sum5", 32'(out_sum5), 32'(EXP_SUM5));
    check("sat sat_flag5", 32'(sat_flag5), 32'(EXP_SAT5));
    drive(mk(0,0,0,1, 1,0,0,36), "sat drain");
    check("sat sticky", 32'(sat_flag5), 32'(EXP_SAT5));
    drive(mk(1,0,0,1, 1,0,0,0), "sat clr");
    check("sat cleared", 32'(sat_flag5), 32'd0);
    check("sat sum5 cleared", 32'(out_sum5), 32'd0);

    // Async reset mid-frame with a nonzero out_sum already registered.
    drive(mk(0,1,2,1, 1,1,0,0), "r1");
    drive(mk(0,1,3,1, 1,2,0,0), "r2");
    drive(mk(0,1,4,1, 1,3,0,0), "r3");
    drive(mk(0,1,5,1, 1,0,1,14), "r4");
    drive(mk(0,0,0,1, 1,0,0,14), "r5");
    drive(mk(0,1,1,1, 1,1,0,14), "r6");
    drive(mk(0,1,1,1, 1,2,0,14), "r7");
    drive(mk(0,1,1,1, 1,3,0,14), "r8");
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("arst tap_idx", 32'(tap_idx), 32'd0);
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst out_sum", 32'(out_sum), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("arst release in_ready", 32'(in_ready), 32'd1);
    drive(mk(0,1,2,1, 1,1,0,0), "p1");
    drive(mk(0,1,2,1, 1,2,0,0), "p2");
    drive(mk(0,1,2,1, 1,3,0,0), "p3");
    drive(mk(0,1,2,1, 1,0,1,8), "p4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
